// File: rtl/carpma_birimi_hatli.sv
// Pipelined M-extension multiplier (MUL/MULH/MULHSU/MULHU). Results leave in order after ASAMA_SAYISI cycles.
// Optional: define CARPMA_SAYAC_EN to add the 32-bit completed-operation counter islem_sayisi_o.
module carpma_birimi_hatli #(
    parameter int VERI_GENISLIK   = 32,
    parameter int ASAMA_SAYISI    = 3,
    parameter int ETIKET_GENISLIK = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       durdur_i,
    input  logic                       gecerli_i,
    input  logic [1:0]                 kontrol_i,
    input  logic [VERI_GENISLIK-1:0]   deger1_i,
    input  logic [VERI_GENISLIK-1:0]   deger2_i,
    input  logic [ETIKET_GENISLIK-1:0] etiket_i,
    output logic [VERI_GENISLIK-1:0]   sonuc_o,
    output logic                       gecerli_o,
    output logic [ETIKET_GENISLIK-1:0] etiket_o
`ifdef CARPMA_SAYAC_EN
    ,
    output logic [31:0]                islem_sayisi_o
`endif
);
    localparam int W = VERI_GENISLIK;
    localparam int S = ASAMA_SAYISI;
    localparam int T = ETIKET_GENISLIK;

    // Same encoding as the decoder's CARPMA_* definitions.
    localparam logic [1:0] CARPMA_MUL    = 2'b00;
    localparam logic [1:0] CARPMA_MULH   = 2'b01;
    localparam logic [1:0] CARPMA_MULHSU = 2'b10;
    localparam logic [1:0] CARPMA_MULHU  = 2'b11;

    logic isaret1, isaret2;
    assign isaret1 = (kontrol_i != CARPMA_MULHU) & deger1_i[W-1];
    assign isaret2 = ((kontrol_i == CARPMA_MUL) || (kontrol_i == CARPMA_MULH)) & deger2_i[W-1];

    logic [S:1]   gecerli_q;
    logic [S:1]   yuksek_q;
    logic [T-1:0] etiket_q [1:S];
    logic [W:0]   deger1_q, deger2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_q <= '0;
        end else if (!durdur_i) begin
            gecerli_q[1] <= gecerli_i;
            for (int k = 2; k <= S; k++) begin
                gecerli_q[k] <= gecerli_q[k-1];
            end
        end
    end

    // NOTE: payload registers have no reset; the valid bits alone decide what is real, and in-flight data is simply discarded.
    always_ff @(posedge clk_i) begin
        if (!durdur_i) begin
            deger1_q    <= {isaret1, deger1_i};
            deger2_q    <= {isaret2, deger2_i};
            yuksek_q[1] <= (kontrol_i != CARPMA_MUL);
            etiket_q[1] <= etiket_i;
            for (int k = 2; k <= S; k++) begin
                yuksek_q[k] <= yuksek_q[k-1];
                etiket_q[k] <= etiket_q[k-1];
            end
        end
    end

    // A 2W-bit product of the sign-extended operands equals the signed (W+1)x(W+1) product truncated to 2W bits.
    logic [2*W-1:0] genis1, genis2, carpim_c, carpim_son;
    assign genis1   = {{(W-1){deger1_q[W]}}, deger1_q};
    assign genis2   = {{(W-1){deger2_q[W]}}, deger2_q};
    assign carpim_c = genis1 * genis2;

    if (S == 1) begin : g_tek_asama
        assign carpim_son = carpim_c;
    end else begin : g_hatli
        // Registers after the multiplier give synthesis room to retime partial products across stages 2..S.
        logic [2*W-1:0] carpim_q [2:S];
        always_ff @(posedge clk_i) begin
            if (!durdur_i) begin
                carpim_q[2] <= carpim_c;
                for (int k = 3; k <= S; k++) begin
                    carpim_q[k] <= carpim_q[k-1];
                end
            end
        end
        assign carpim_son = carpim_q[S];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gecerli_o <= 1'b0;
            sonuc_o   <= '0;
            etiket_o  <= '0;
        end else if (!durdur_i) begin
            gecerli_o <= gecerli_q[S];
            if (gecerli_q[S]) begin
                sonuc_o  <= yuksek_q[S] ? carpim_son[2*W-1:W] : carpim_son[W-1:0];
                etiket_o <= etiket_q[S];
            end
        end
    end

`ifdef CARPMA_SAYAC_EN
    // A result held through a stall is counted once, on the edge that releases it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            islem_sayisi_o <= '0;
        end else if (gecerli_o && !durdur_i) begin
            islem_sayisi_o <= islem_sayisi_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_carpma_birimi_hatli.sv
// Self-checking bench for carpma_birimi_hatli: W=32/S=3 and W=8/S=1 instances against an arithmetic reference model.
// Counter checks are compiled in when CARPMA_SAYAC_EN is defined.
module tb_carpma_birimi_hatli;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    localparam int S_A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_durdur, a_gec_i, a_gec_o;
    logic [1:0]  a_kontrol;
    logic [31:0] a_d1, a_d2, a_sonuc;
    logic [4:0]  a_et_i, a_et_o;
`ifdef CARPMA_SAYAC_EN
    logic [31:0] a_sayac;
`endif
    logic        b_durdur, b_gec_i, b_gec_o;
    logic [1:0]  b_kontrol;
    logic [7:0]  b_d1, b_d2, b_sonuc;
    logic [3:0]  b_et_i, b_et_o;

    logic [37:0] a_obs;
    logic [12:0] b_obs;
    assign a_obs = {a_gec_o, a_et_o, a_sonuc};
    assign b_obs = {b_gec_o, b_et_o, b_sonuc};

    int n_chk = 0;
    int n_fail = 0;

    carpma_birimi_hatli #(.VERI_GENISLIK(32), .ASAMA_SAYISI(S_A), .ETIKET_GENISLIK(5)) u_a (
        .clk_i(clk), .rst_i(rst), .durdur_i(a_durdur), .gecerli_i(a_gec_i), .kontrol_i(a_kontrol),
        .deger1_i(a_d1), .deger2_i(a_d2), .etiket_i(a_et_i),
        .sonuc_o(a_sonuc), .gecerli_o(a_gec_o), .etiket_o(a_et_o)
`ifdef CARPMA_SAYAC_EN
        , .islem_sayisi_o(a_sayac)
`endif
    );

    carpma_birimi_hatli #(.VERI_GENISLIK(8), .ASAMA_SAYISI(1), .ETIKET_GENISLIK(4)) u_b (
        .clk_i(clk), .rst_i(rst), .durdur_i(b_durdur), .gecerli_i(b_gec_i), .kontrol_i(b_kontrol),
        .deger1_i(b_d1), .deger2_i(b_d2), .etiket_i(b_et_i),
        .sonuc_o(b_sonuc), .gecerli_o(b_gec_o), .etiket_o(b_et_o)
`ifdef CARPMA_SAYAC_EN
        , .islem_sayisi_o()
`endif
    );

    typedef struct {
        int          due;
        logic [4:0]  t;
        logic [31:0] r;
    } beklenen_t;

    // Reference: operands as mathematical integers per operation, exact 64-bit product, then pick the half.
    function automatic logic [31:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [31:0] x, input logic [31:0] y);
        longint unsigned mask, ux, uy, p, r;
        longint sx, sy;
        mask = (64'd1 << w) - 64'd1;
        ux = {32'd0, x} & mask;
        uy = {32'd0, y} & mask;
        sx = x[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
        sy = y[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
        if (op == OP_MULHU)       p = ux * uy;
        else if (op == OP_MULHSU) p = sx * longint'(uy);
        else                      p = sx * sy;
        if (op == OP_MUL) r = p & mask;
        else              r = (p >> w) & mask;
        return r[31:0];
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_a(input logic v, input logic [1:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] t);
        a_gec_i = v; a_kontrol = op; a_d1 = x; a_d2 = y; a_et_i = t;
    endtask

    task automatic drive_b(input logic v, input logic [1:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] t);
        b_gec_i = v; b_kontrol = op; b_d1 = x; b_d2 = y; b_et_i = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_durdur = 1'b1;
        drive_a(1'b1, OP_MUL, 32'd3, 32'd4, 5'd1);
        drive_b(1'b1, OP_MUL, 8'd3, 8'd4, 4'd1);
        repeat (2) @(negedge clk);
        n_chk++;
        if (a_obs !== 38'd0) begin n_fail++; $display("FAIL reset_a: got %h expected 0", a_obs); end
        n_chk++;
        if (b_obs !== 13'd0) begin n_fail++; $display("FAIL reset_b: got %h expected 0", b_obs); end
`ifdef CARPMA_SAYAC_EN
        n_chk++;
        if (a_sayac !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", a_sayac); end
`endif
        rst = 1'b0;
        a_durdur = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        drive_b(1'b0, OP_MUL, 8'd0, 8'd0, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_single();
        drive_a(1'b1, OP_MUL, 32'd121, 32'hFFFF_FFBA, 5'd7);
        @(negedge clk);
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        for (int k = 0; k < S_A; k++) begin
            n_chk++;
            if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL single_early[%0d]: got gecerli_o=%b expected 0", k, a_gec_o); end
            @(negedge clk);
        end
        n_chk++;
        if (a_obs !== {1'b1, 5'd7, 32'hFFFF_DEEA})
            begin n_fail++; $display("FAIL single_result: got %h expected %h", a_obs, {1'b1, 5'd7, 32'hFFFF_DEEA}); end
        @(negedge clk);
        n_chk++;
        if (a_obs !== {1'b0, 5'd7, 32'hFFFF_DEEA})
            begin n_fail++; $display("FAIL single_hold: got %h expected %h", a_obs, {1'b0, 5'd7, 32'hFFFF_DEEA}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] x1  [3] = '{32'h0011_0000, 32'h0011_0000, 32'hFFFF_FFFF};
        logic [31:0] x2  [3] = '{32'h0003_0000, 32'hFFFF_FFFF, 32'h0011_0000};
        logic [31:0] ex  [3] = '{32'h0000_0033, 32'h0010_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, ops[i], x1[i], x2[i], 5'(i + 1));
            @(negedge clk);
        end
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        n_chk++;
        if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got gecerli_o=%b expected 0", a_gec_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (a_obs !== {1'b1, 5'(i + 1), ex[i]})
                begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, a_obs, {1'b1, 5'(i + 1), ex[i]}); end
        end
        @(negedge clk);
        n_chk++;
        if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got gecerli_o=%b expected 0", a_gec_o); end
    endtask

    task automatic test_stall();
        drive_a(1'b1, OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd4);
        @(negedge clk);
        a_durdur = 1'b1;
        drive_a(1'b1, OP_MUL, 32'd3, 32'd3, 5'd9);
        repeat (2) @(negedge clk);
        a_durdur = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL stall_early[%0d]: got gecerli_o=%b expected 0", k, a_gec_o); end
        end
        @(negedge clk);
        n_chk++;
        if (a_obs !== {1'b1, 5'd4, 32'h4000_0000})
            begin n_fail++; $display("FAIL stall_result: got %h expected %h", a_obs, {1'b1, 5'd4, 32'h4000_0000}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL stall_ignored_input[%0d]: got gecerli_o=%b expected 0", k, a_gec_o); end
        end
        // Stall while a result is on the outputs: it must stay visible and unchanged.
        drive_a(1'b1, OP_MUL, 32'd5, 32'd6, 5'd10);
        @(negedge clk);
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        repeat (S_A) @(negedge clk);
        n_chk++;
        if (a_obs !== {1'b1, 5'd10, 32'd30})
            begin n_fail++; $display("FAIL freeze_before: got %h expected %h", a_obs, {1'b1, 5'd10, 32'd30}); end
        a_durdur = 1'b1;
        drive_a(1'b1, OP_MUL, 32'd7, 32'd7, 5'd11);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (a_obs !== {1'b1, 5'd10, 32'd30})
                begin n_fail++; $display("FAIL freeze_hold[%0d]: got %h expected %h", k, a_obs, {1'b1, 5'd10, 32'd30}); end
        end
        a_durdur = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (a_obs !== {1'b0, 5'd10, 32'd30})
                begin n_fail++; $display("FAIL freeze_after[%0d]: got %h expected %h", k, a_obs, {1'b0, 5'd10, 32'd30}); end
        end
    endtask

    task automatic test_reset_midflight();
        drive_a(1'b1, OP_MUL, 32'd2, 32'd3, 5'd1);
        @(negedge clk);
        drive_a(1'b1, OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        @(negedge clk);
        drive_a(1'b1, OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (a_obs !== 38'd0) begin n_fail++; $display("FAIL midreset_quiet[%0d]: got %h expected 0", k, a_obs); end
            @(negedge clk);
        end
        drive_a(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        @(negedge clk);
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        repeat (S_A - 1) @(negedge clk);
        n_chk++;
        if (a_gec_o !== 1'b0) begin n_fail++; $display("FAIL midreset_early: got gecerli_o=%b expected 0", a_gec_o); end
        @(negedge clk);
        n_chk++;
        if (a_obs !== {1'b1, 5'd31, 32'hFFFF_FFFE})
            begin n_fail++; $display("FAIL midreset_after: got %h expected %h", a_obs, {1'b1, 5'd31, 32'hFFFF_FFFE}); end
        @(negedge clk);
    endtask

    task automatic test_w8();
        logic [1:0] ops [4] = '{OP_MULHSU, OP_MUL, OP_MULHU, OP_MULH};
        logic [7:0] ex  [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
        logic       pv, ev;
        logic [7:0] ps, es, x, y;
        logic [3:0] pt, et, t;
        logic [1:0] op;
        logic [31:0] r;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive_b(1'b1, ops[i], 8'h80, 8'hFF, 4'(i + 1));
            else       drive_b(1'b0, OP_MUL, 8'h00, 8'h00, 4'd0);
            @(negedge clk);
            n_chk++;
            if (i == 0) begin
                if (b_gec_o !== 1'b0) begin n_fail++; $display("FAIL w8_early: got gecerli_o=%b expected 0", b_gec_o); end
            end else if (b_obs !== {1'b1, 4'(i), ex[i-1]}) begin
                n_fail++; $display("FAIL w8_corner[%0d]: got %h expected %h", i - 1, b_obs, {1'b1, 4'(i), ex[i-1]});
            end
        end
        @(negedge clk);
        n_chk++;
        if (b_obs !== {1'b0, 4'd4, 8'h00}) begin n_fail++; $display("FAIL w8_idle: got %h expected %h", b_obs, {1'b0, 4'd4, 8'h00}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pv = 1'b0; ps = 8'h00; pt = 4'd0; ev = 1'b0; es = 8'h00; et = 4'd0;
        for (int c = 0; c < 41; c++) begin
            op = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 0) ? 8'h80 : 8'hFF);
            y = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'($urandom);
            t = 4'($urandom);
            if (c < 40) drive_b(($urandom_range(0, 3) != 0), op, x, y, t);
            else        drive_b(1'b0, OP_MUL, 8'h00, 8'h00, 4'd0);
            @(negedge clk);
            ev = pv;
            if (pv) begin es = ps; et = pt; end
            n_chk++;
            if (b_obs !== {ev, et, es}) begin n_fail++; $display("FAIL w8_rand[%0d]: got %h expected %h", c, b_obs, {ev, et, es}); end
            r = ref_mul(8, b_kontrol, {24'd0, b_d1}, {24'd0, b_d2});
            pv = b_gec_i; ps = r[7:0]; pt = b_et_i;
        end
    endtask

    task automatic test_random();
        beklenen_t   q[$];
        int          adv;
        logic        ev, st, v;
        logic [31:0] es, x, y;
        logic [4:0]  et, t;
        logic [1:0]  op;
        logic [31:0] cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        adv = 0; ev = 1'b0; es = 32'd0; et = 5'd0; cnt = 32'd0;
        for (int c = 0; c < 300 + S_A + 3; c++) begin
            st = (c < 300) && ($urandom_range(0, 99) < 15);
            v  = (c < 300) && ($urandom_range(0, 99) < 75);
            op = 2'($urandom_range(0, 3));
            x  = pick32();
            y  = pick32();
            t  = 5'($urandom);
            a_durdur = st;
            drive_a(v, op, x, y, t);
            if (!st) begin
                if (ev) cnt = cnt + 32'd1;
                adv++;
                if (v) q.push_back('{due: adv + S_A, t: t, r: ref_mul(32, op, x, y)});
                if (q.size() > 0 && q[0].due == adv) begin
                    ev = 1'b1; es = q[0].r; et = q[0].t;
                    void'(q.pop_front());
                end else begin
                    ev = 1'b0;
                end
            end
            @(negedge clk);
            n_chk++;
            if (a_obs !== {ev, et, es}) begin n_fail++; $display("FAIL rand[%0d]: got %h expected %h", c, a_obs, {ev, et, es}); end
`ifdef CARPMA_SAYAC_EN
            n_chk++;
            if (a_sayac !== cnt) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %h expected %h", c, a_sayac, cnt); end
`endif
        end
        a_durdur = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
    endtask

`ifdef CARPMA_SAYAC_EN
    task automatic test_counter();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, OP_MUL, 32'(i + 2), 32'd3, 5'(i + 1));
            @(negedge clk);
        end
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        a_durdur = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_obs, a_sayac} !== {1'b1, 5'd3, 32'd12, 32'd2})
            begin n_fail++; $display("FAIL cnt_stall: got %h/%h expected %h/2", a_obs, a_sayac, {1'b1, 5'd3, 32'd12}); end
        a_durdur = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (a_sayac !== 32'd5) begin n_fail++; $display("FAIL cnt_five: got %h expected 5", a_sayac); end
        @(negedge clk);
        force u_a.islem_sayisi_o = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_a.islem_sayisi_o;
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, OP_MULHU, 32'd9, 32'd9, 5'd20);
            @(negedge clk);
        end
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        repeat (S_A + 2) @(negedge clk);
        n_chk++;
        if (a_sayac !== 32'h0000_0001) begin n_fail++; $display("FAIL cnt_wrap: got %h expected 00000001", a_sayac); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_durdur = 1'b0;
        b_durdur = 1'b0;
        drive_a(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0);
        drive_b(1'b0, OP_MUL, 8'd0, 8'd0, 4'd0);
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_w8();
        test_random();
`ifdef CARPMA_SAYAC_EN
        test_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/carpma_birimi_hatli.md
Name: carpma_birimi_hatli

Overview:
Parametrised, fully pipelined successor to the single-cycle M-extension multiplier in the execute stage. It accepts one MUL/MULH/MULHSU/MULHU operation per cycle and returns results in order after a fixed ASAMA_SAYISI-cycle latency. A tag travels with each operation so the issue logic can match results to destination registers. A global stall freezes the whole pipe.

Parameters:
VERI_GENISLIK, 32, operand and result width W (8..64).
ASAMA_SAYISI, 3, pipeline depth S (>=1); input-to-output latency in cycles.
ETIKET_GENISLIK, 5, tag width T.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
durdur_i  input  1  stall; 1 freezes all stages, the input and the outputs.
gecerli_i  input  1  operation valid at the input.
kontrol_i  input  2  operation select, encoded with CARPMA_MUL / CARPMA_MULH / CARPMA_MULHSU / CARPMA_MULHU from tanimlamalar.vh.
deger1_i  input  W  rs1 operand.
deger2_i  input  W  rs2 operand.
etiket_i  input  T  tag carried with the operation.
sonuc_o  output  W  result.
gecerli_o  output  1  sonuc_o/etiket_o valid this cycle.
etiket_o  output  T  tag of the result.
islem_sayisi_o  output  32  completed-operation count; present only with CARPMA_SAYAC_EN.

Behaviour:
- Reset: clock is clk_i; reset is rst_i, synchronous and active-high. On a clock edge with rst_i=1, all stage valid bits, gecerli_o, sonuc_o, etiket_o and islem_sayisi_o go to 0. Reset overrides durdur_i. In-flight operations are discarded and never appear at the output.
- Input acceptance: an operation is accepted on an edge where gecerli_i=1, durdur_i=0 and rst_i=0. Without a stall there is no backpressure and one operation is accepted per cycle.
- Operand extension to W+1 bits:
  - MUL: both operands signed.
  - MULH: both operands signed.
  - MULHSU: deger1_i signed, deger2_i unsigned.
  - MULHU: both operands unsigned.
- Product: signed (W+1)x(W+1) multiply, truncated to 2W bits. MUL returns bits [W-1:0]. The other three operations return bits [2W-1:W].
- Pipeline structure: stage 1 registers the extended operands, the operation and the tag. The product may be split into partial products across stages 2..S in any arrangement. With S=1, the product is computed combinationally and registered once.
- Latency: an operation accepted at edge n gives gecerli_o=1 for exactly one cycle after edge n+S, assuming no stall cycles. Results leave in issue order. Back-to-back inputs give back-to-back outputs.
- Stall: while durdur_i=1, every stage register, gecerli_o, sonuc_o and etiket_o hold their values, and input is ignored. Each stall cycle delays an in-flight result by one cycle. A result shown while stalled stays visible and counts as one completion when the stall ends.
- When gecerli_o=0, sonuc_o and etiket_o hold the last valid values (0 after reset).
- Boundary results:
  - MULH of MIN*MIN gives 0x40000000 (W=32).
  - Any operand 0 gives 0.
  - A negative times 1 under MUL gives the operand unchanged.
- No overflow flags; no division.

Optional Feature:
CARPMA_SAYAC_EN
- Defined: islem_sayisi_o is a 32-bit counter. It increments on each edge where gecerli_o=1 and durdur_i=0 on the following cycle boundary, i.e. once per delivered result. It wraps from 0xFFFFFFFF to 0 and is cleared by rst_i.
- Undefined: the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
1. W=32, S=3: MUL with 121 and -70 (0xFFFFFFBA), tag 7 accepted at edge 0 -> gecerli_o=1 only after edge 3, sonuc_o=0xFFFFDEEA, etiket_o=7.
2. Consecutive cycles, tags 1/2/3:
   - MULH 0x00110000 x 0x00030000 -> 0x00000033
   - MULHU 0x00110000 x 0xFFFFFFFF -> 0x0010FFFF
   - MULHSU 0xFFFFFFFF x 0x00110000 -> 0xFFFFFFFF
   -> results on three consecutive cycles in tag order 1, 2, 3.
3. Stall: issue MULH 0x80000000 x 0x80000000, then hold durdur_i=1 for 2 cycles at edge 1 -> result 0x40000000 appears after edge 5. Outputs are frozen during the stall. A second input presented while stalled is not accepted.
4. Reset mid-flight: issue 3 operations, assert rst_i for one cycle at edge 2 -> gecerli_o stays 0 for the next 5 cycles, sonuc_o=0, etiket_o=0. An operation issued after reset returns correctly.
5. W=8, S=1: 0x80 x 0xFF:
   - MULHSU -> 0x80 one cycle later
   - MUL -> 0x80
   - MULHU -> 0x7F
   - MULH -> 0x00
6. CARPMA_SAYAC_EN defined: 5 operations with a 1-cycle stall during the 3rd result -> islem_sayisi_o=5 after the last result. Preload the counter near 0xFFFFFFFF via a force, then deliver 2 results -> counter wraps to 0x00000001.
